// File: rtl/uart_rx_framer.sv
// uart_rx_framer
// ---------------------------------------------------------------------------
// UART receive framer. It detects a start edge on the synchronised serial
// line, runs an external RX baud generator through baud_en, and assembles
// 8 data bits LSB-first. It can check an optional parity bit, and then
// checks the stop bit. Good bytes land in a one-entry holding register that
// uses a valid/ready handshake. Errors are reported as single-cycle pulses.
//
// Build option:
//   UART_RX_PARITY_EN  defined   -> 8 data + 1 parity + 1 stop (8E1 / 8O1)
//                      undefined -> 8N1, parity_err tied low
//
// Parameters:
//   PARITY_ODD  0 = even parity, 1 = odd parity (used with UART_RX_PARITY_EN)
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset
//   rxd         asynchronous serial input, idles high
//   baud_tick   one-cycle sample strobe from the RX baud generator
//   baud_en     enables the RX baud generator while a frame is in progress
//   rx_data     received byte, stable while rx_valid is high
//   rx_valid    holding register is full
//   rx_ready    consumer accepts the byte when rx_valid & rx_ready
//   frame_err   one-cycle pulse: stop bit sampled low
//   parity_err  one-cycle pulse: parity mismatch
//   overrun     one-cycle pulse: good byte dropped because holding was full
//
// State table:
//   state     | meaning
//   ----------+--------------------------------------------------------
//   IDLE      | line idle, waiting for a 1->0 transition on rxd_s
//   DATA      | sampling the 8 data bits, one per baud_tick
//   PARITY    | sampling the parity bit (parity build only)
//   STOP      | sampling the stop bit and deciding the frame's fate
//   WAIT_HIGH | framing error/break seen, waiting for the line to go high
// ---------------------------------------------------------------------------
module uart_rx_framer #(
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       baud_tick,
  output logic       baud_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t     state;
  state_t     state_next;

  logic       rxd_meta;
  logic       rxd_s;
  logic       rxd_prev;
  logic       start_edge;

  logic [7:0] shift_reg;
  logic [7:0] shift_next;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;

  logic       frame_good;
  logic       frame_fault;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = (PARITY_ODD != 0);

  logic       par_bad;
  logic       parity_sample;
  logic       parity_fault;
  logic       parity_err_q;
`endif

  // Only 0 and 1 are meaningful for the parity sense.
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_cfg_check
    $error("uart_rx_framer: PARITY_ODD must be 0 or 1");
  end

  // -------------------------------------------------------------------------
  // Input synchroniser plus one history flop for edge detection. All three
  // flops reset high, so an idle line can never look like a start edge
  // right after reset.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign start_edge = rxd_prev & ~rxd_s;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    shift_next   = shift_reg;
    bit_cnt_next = bit_cnt;
    frame_good   = 1'b0;
    frame_fault  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_sample = 1'b0;
    parity_fault  = 1'b0;
`endif

    unique case (state)
      IDLE: begin
        // baud_tick is deliberately ignored here.
        if (start_edge) begin
          state_next   = DATA;
          bit_cnt_next = '0;
        end
      end

      DATA: begin
        if (baud_tick) begin
          shift_next   = {rxd_s, shift_reg[7:1]};
          bit_cnt_next = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (baud_tick) begin
          parity_sample = 1'b1;
          state_next    = STOP;
        end
      end
`endif

      STOP: begin
        if (baud_tick) begin
          if (!rxd_s) begin
            // A framing error takes priority over a parity mismatch.
            frame_fault = 1'b1;
            state_next  = WAIT_HIGH;
          end
`ifdef UART_RX_PARITY_EN
          else if (par_bad) begin
            parity_fault = 1'b1;
            state_next   = IDLE;
          end
`endif
          else begin
            frame_good = 1'b1;
            state_next = IDLE;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low line (break) must not be taken as a new start bit.
        // We leave only once the line is high again, so IDLE then needs a
        // real 1->0 transition.
        if (rxd_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath, baud enable, holding register and error pulses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      baud_en   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= bit_cnt_next;

      // baud_en is registered from the next state. It therefore rises on
      // the edge that detects the start bit and falls on the stop-tick edge.
      baud_en   <= (state_next == DATA) || (state_next == PARITY) ||
                   (state_next == STOP);

      frame_err <= frame_fault;
      overrun   <= 1'b0;

      if (frame_good) begin
        // A byte accepted on this same edge frees the slot for the new byte.
        if (!rx_valid || rx_ready) begin
          rx_data  <= shift_reg;
          rx_valid <= 1'b1;
        end else begin
          overrun  <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  // -------------------------------------------------------------------------
  // Parity check. At the parity tick the shift register already holds all
  // 8 data bits. The mismatch flag is held until the stop bit is judged.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par_bad      <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_fault;
      if (parity_sample) begin
        par_bad <= rxd_s ^ ((^shift_reg) ^ PAR_SENSE);
      end else if (state == IDLE) begin
        par_bad <= 1'b0;
      end
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_framer.sv
// Testbench for uart_rx_framer. A baud-generator model answers baud_en. A
// scoreboard of expected events (data byte, frame_err, parity_err, overrun)
// is filled when frames are driven, and a monitor drains it as the DUT
// reports them.
module tb_uart_rx_framer;

  localparam int PAR_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? 10 : 9;  // ticks per frame (data+parity+stop)

  logic       clk;
  logic       rst;
  logic       rxd;
  logic       baud_tick;
  logic       baud_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  uart_rx_framer #(.PARITY_ODD(PAR_ODD)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .baud_tick  (baud_tick),
    .baud_en    (baud_en),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  typedef enum int {EV_DATA, EV_FERR, EV_PERR, EV_OVR} ev_kind_e;

  typedef struct {
    ev_kind_e   kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    ev_kind_e   kind;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  int   first_cyc = 24;
  int   bit_cyc   = 16;
  logic force_tick = 1'b0;
  int   tick_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud generator model: first strobe first_cyc clocks after baud_en
  // rises, then one every bit_cyc clocks.
  initial begin
    int bcnt;
    bcnt      = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!baud_en) begin
        bcnt      = 0;
        tick_cnt  = 0;
        baud_tick = force_tick;
      end else begin
        bcnt++;
        baud_tick = (bcnt >= first_cyc) && (((bcnt - first_cyc) % bit_cyc) == 0);
        if (baud_tick) tick_cnt++;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input ev_kind_e k, input logic [7:0] d);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL event: got %s %02h, expected no event", k.name(), d);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || (k == EV_DATA && e.data !== d)) begin
        errors++;
        $display("FAIL event: got %s %02h, expected %s %02h", k.name(), d, e.kind.name(), e.data);
      end
    end
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ PAR_ODD[0];
  endfunction

  function automatic ev_kind_e model_kind(input logic [7:0] d, input logic par, input logic stop);
    if (!stop) return EV_FERR;
    if (PAR_EN && par !== good_par(d)) return EV_PERR;
    return EV_DATA;
  endfunction

  task automatic push(input ev_kind_e k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives start, data LSB-first, optional parity, stop. A low stop bit can
  // be stretched by low_hold bit periods. abort_at >= 0 returns mid-way
  // through that bit position, with the line left at that bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int low_hold, input int abort_at);
    logic seq[11];
    int   n;
    seq[0] = 1'b0;
    for (int i = 0; i < 8; i++) seq[1 + i] = d[i];
    n = 9;
    if (PAR_EN) begin
      seq[n] = par;
      n++;
    end
    seq[n] = stop;
    n++;
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      rxd = seq[i];
      if (i == abort_at) begin
        step(bit_cyc / 2);
        return;
      end
      step(bit_cyc);
    end
    if (!stop) step(low_hold * bit_cyc);
    rxd = 1'b1;
    step(2 * bit_cyc + 6);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600 && sb.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check(name, sb.size(), 0);
  endtask

  // Monitor: turns DUT outputs into events and checks the pulses are single-cycle.
  initial begin
    logic pv, pr, pf, pp, po;
    pv = 0; pr = 0; pf = 0; pp = 0; po = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid && (!pv || pr)) sb_pop(EV_DATA, rx_data);
        if (frame_err) begin
          sb_pop(EV_FERR, 8'h00);
          check("frame_err width", pf, 1'b0);
        end
        if (parity_err) begin
          sb_pop(EV_PERR, 8'h00);
          check("parity_err width", pp, 1'b0);
        end
        if (overrun) begin
          sb_pop(EV_OVR, 8'h00);
          check("overrun width", po, 1'b0);
        end
      end
      pv = rx_valid; pr = rx_ready; pf = frame_err; pp = parity_err; po = overrun;
    end
  end

  vec_t vecs[10];

  initial begin
    vecs = '{
      '{8'h00, 1'b0, 1'b1, EV_DATA},
      '{8'hFF, 1'b0, 1'b1, EV_DATA},
      '{8'hA3, 1'b0, 1'b1, EV_DATA},
      '{8'hA3, 1'b1, 1'b1, EV_DATA},
      '{8'h5A, 1'b0, 1'b0, EV_DATA},
      '{8'h80, 1'b1, 1'b1, EV_DATA},
      '{8'h01, 1'b1, 1'b1, EV_DATA},
      '{8'h3C, 1'b0, 1'b1, EV_DATA},
      '{8'hC3, 1'b1, 1'b0, EV_DATA},
      '{8'h7F, 1'b0, 1'b1, EV_DATA}
    };
    foreach (vecs[i]) vecs[i].kind = model_kind(vecs[i].d, vecs[i].par, vecs[i].stop);

    rst = 1'b1;
    rxd = 1'b1;
    rx_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("reset baud_en", baud_en, 1'b0);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset rx_data", rx_data, 8'h00);
    check("reset frame_err", frame_err, 1'b0);
    check("reset parity_err", parity_err, 1'b0);
    check("reset overrun", overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("idle after release baud_en", baud_en, 1'b0);

    // Strobes while idle must be ignored
    repeat (2) begin
      @(negedge clk); force_tick = 1'b1;
      @(negedge clk); @(negedge clk); force_tick = 1'b0;
      @(negedge clk);
    end
    repeat (4) @(posedge clk);
    #2;
    check("idle ticks ignored baud_en", baud_en, 1'b0);

    // 0x55 with baud_en window and delivery latency
    push(EV_DATA, 8'h55);
    fork
      send_frame(8'h55, good_par(8'h55), 1'b1, 0, -1);
      begin
        int   hi;
        logic last_t;
        bit   seen;
        hi = 0; last_t = 0; seen = 0;
        for (int i = 0; i < 2000; i++) begin
          @(posedge clk);
          #2;
          if (baud_en) begin
            seen = 1; hi++; last_t = baud_tick;
          end else if (seen) begin
            break;
          end
        end
        check("baud_en high cycles", hi, first_cyc + (NB - 1) * bit_cyc);
        check("last enabled cycle carries stop tick", last_t, 1'b1);
        check("rx_valid after stop tick", rx_valid, 1'b1);
        check("rx_data after stop tick", rx_data, 8'h55);
      end
    join
    wait_drain("drain 0x55");

    // Table-driven frames
    for (int i = 0; i < 10; i++) begin
      push(vecs[i].kind, vecs[i].d);
      send_frame(vecs[i].d, vecs[i].par, vecs[i].stop, 0, -1);
      wait_drain($sformatf("drain vec %0d", i));
    end

    // Strobes on consecutive cycles
    first_cyc = 1;
    bit_cyc   = 1;
    push(EV_DATA, 8'hC5);
    send_frame(8'hC5, good_par(8'hC5), 1'b1, 0, -1);
    wait_drain("drain fast 0xC5");
    push(EV_FERR, 8'h00);
    send_frame(8'h96, good_par(8'h96), 1'b0, 0, -1);
    wait_drain("drain fast ferr");
    first_cyc = 24;
    bit_cyc   = 16;

    // Break: stop low and line held low for 5 bit periods
    push(EV_FERR, 8'h00);
    fork
      send_frame(8'h0F, good_par(8'h0F), 1'b0, 5, -1);
      begin
        int en_hi, low_seen;
        bit fe;
        en_hi = 0; low_seen = 0; fe = 0;
        for (int i = 0; i < 3000 && !(fe && rxd); i++) begin
          @(posedge clk);
          #2;
          if (frame_err) fe = 1;
          else if (fe && !rxd) begin
            low_seen++;
            if (baud_en) en_hi++;
          end
        end
        check("break frame_err seen", fe, 1'b1);
        check("break baud_en stays low", en_hi, 0);
        check("break held low long enough", low_seen >= 5 * bit_cyc, 1'b1);
      end
    join
    wait_drain("drain break");

    // Overrun: consumer not ready
    rx_ready = 1'b0;
    push(EV_DATA, 8'h11);
    send_frame(8'h11, good_par(8'h11), 1'b1, 0, -1);
    wait_drain("drain 0x11");
    push(EV_OVR, 8'h00);
    send_frame(8'h22, good_par(8'h22), 1'b1, 0, -1);
    wait_drain("drain overrun");
    check("overrun keeps rx_data", rx_data, 8'h11);
    check("overrun keeps rx_valid", rx_valid, 1'b1);

    // Delivery coinciding with acceptance
    push(EV_DATA, 8'h22);
    fork
      send_frame(8'h22, good_par(8'h22), 1'b1, 0, -1);
      begin
        bit hit;
        hit = 0;
        for (int i = 0; i < 3000; i++) begin
          @(posedge clk);
          #2;
          if (baud_tick && tick_cnt == NB) begin
            hit = 1;
            break;
          end
        end
        check("stop tick found", hit, 1'b1);
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    wait_drain("drain coincident");
    check("coincident rx_data", rx_data, 8'h22);
    check("coincident rx_valid", rx_valid, 1'b1);

    // Reset during data bit 4
    send_frame(8'hE7, good_par(8'hE7), 1'b1, 0, 5);
    #1;
    check("mid-frame baud_en", baud_en, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst baud_en", baud_en, 1'b0);
    check("async rst rx_valid", rx_valid, 1'b0);
    check("async rst rx_data", rx_data, 8'h00);
    check("async rst frame_err", frame_err, 1'b0);
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #2;
    check("after rst baud_en", baud_en, 1'b0);
    check("after rst rx_valid", rx_valid, 1'b0);
    check("scoreboard empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
